// File: rtl/axis_merge.sv
// Two-to-one AXI-stream merge with per-packet round-robin arbitration.
// Packets are forwarded whole; the grant is held from first beat to TLAST.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   axis_in0_*         input stream 0 (tdata/tlast/tvalid in, tready out)
//   axis_in1_*         input stream 1 (tdata/tlast/tvalid in, tready out)
//   axis_out_*         merged stream (tdata/tlast/tvalid/tid out, tready in)
//   active_port        registered current or most recent grant
//   busy               a packet is locked
//   packet_strb        pulse on every output TLAST handshake
//   pkt_count0/1       completed packets per source port (wrapping)
module axis_merge #(
    parameter int DW = 512,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic [DW-1:0] axis_in0_tdata,
    input  logic          axis_in0_tlast,
    input  logic          axis_in0_tvalid,
    output logic          axis_in0_tready,

    input  logic [DW-1:0] axis_in1_tdata,
    input  logic          axis_in1_tlast,
    input  logic          axis_in1_tvalid,
    output logic          axis_in1_tready,

    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tlast,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready,
    output logic          axis_out_tid,

    output logic          active_port,
    output logic          busy,
    output logic          packet_strb,
    output logic [CW-1:0] pkt_count0,
    output logic [CW-1:0] pkt_count1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state_q;
    state_t        state_d;
    logic          last_grant_q;
    logic          last_grant_d;
    logic          active_q;
    logic          active_d;
    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;
    logic          pick0;
    logic          pick1;
    logic          eop0;
    logic          eop1;

    // Mutually exclusive requests: on contention the port that did not
    // win last time takes the grant.
    assign pick0 = axis_in0_tvalid
                 & (~axis_in1_tvalid | last_grant_q);
    assign pick1 = axis_in1_tvalid
                 & (~axis_in0_tvalid | ~last_grant_q);

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        active_d        = active_q;
        axis_out_tdata  = '0;
        axis_out_tlast  = 1'b0;
        axis_out_tvalid = 1'b0;
        axis_out_tid    = 1'b0;
        axis_in0_tready = 1'b0;
        axis_in1_tready = 1'b0;
        eop0            = 1'b0;
        eop1            = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    pick0: begin
                        state_d      = PKT0;
                        last_grant_d = 1'b0;
                        active_d     = 1'b0;
                    end
                    pick1: begin
                        state_d      = PKT1;
                        last_grant_d = 1'b1;
                        active_d     = 1'b1;
                    end
                    default: ;
                endcase
            end
            PKT0: begin
                axis_out_tdata  = axis_in0_tdata;
                axis_out_tlast  = axis_in0_tlast;
                axis_out_tvalid = axis_in0_tvalid;
                axis_out_tid    = 1'b0;
                axis_in0_tready = axis_out_tready;
                eop0 = axis_in0_tvalid
                     & axis_out_tready
                     & axis_in0_tlast;
                if (eop0) begin
                    state_d = IDLE;
                end
            end
            PKT1: begin
                axis_out_tdata  = axis_in1_tdata;
                axis_out_tlast  = axis_in1_tlast;
                axis_out_tvalid = axis_in1_tvalid;
                axis_out_tid    = 1'b1;
                axis_in1_tready = axis_out_tready;
                eop1 = axis_in1_tvalid
                     & axis_out_tready
                     & axis_in1_tlast;
                if (eop1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            active_q     <= active_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (eop0) begin
                cnt0_q <= cnt0_q + CNT_ONE;
            end
            if (eop1) begin
                cnt1_q <= cnt1_q + CNT_ONE;
            end
        end
    end

    assign packet_strb = eop0 | eop1;
    assign busy        = (state_q != IDLE);
    assign active_port = active_q;
    assign pkt_count0  = cnt0_q;
    assign pkt_count1  = cnt1_q;

endmodule

// File: tb/tb_axis_merge.sv
// Scoreboard testbench for axis_merge.
// Per-port drivers feed beats; a monitor checks every output handshake.
module tb_axis_merge;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] axis_in0_tdata;
    logic          axis_in0_tlast;
    logic          axis_in0_tvalid;
    logic          axis_in0_tready;
    logic [DW-1:0] axis_in1_tdata;
    logic          axis_in1_tlast;
    logic          axis_in1_tvalid;
    logic          axis_in1_tready;
    logic [DW-1:0] axis_out_tdata;
    logic          axis_out_tlast;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic          axis_out_tid;
    logic          active_port;
    logic          busy;
    logic          packet_strb;
    logic [CW-1:0] pkt_count0;
    logic [CW-1:0] pkt_count1;

    logic v0;
    logic v1;
    logic force_v0;

    assign axis_in0_tvalid = v0 | force_v0;
    assign axis_in1_tvalid = v1;

    axis_merge #(.DW(DW), .CW(CW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .axis_in0_tdata  (axis_in0_tdata),
        .axis_in0_tlast  (axis_in0_tlast),
        .axis_in0_tvalid (axis_in0_tvalid),
        .axis_in0_tready (axis_in0_tready),
        .axis_in1_tdata  (axis_in1_tdata),
        .axis_in1_tlast  (axis_in1_tlast),
        .axis_in1_tvalid (axis_in1_tvalid),
        .axis_in1_tready (axis_in1_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tid    (axis_out_tid),
        .active_port     (active_port),
        .busy            (busy),
        .packet_strb     (packet_strb),
        .pkt_count0      (pkt_count0),
        .pkt_count1      (pkt_count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            bub;
        bit            last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        bit            last;
        logic [DW-1:0] data;
    } exp_t;

    beat_t sq0[$];
    beat_t sq1[$];
    exp_t  eq0[$];
    exp_t  eq1[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int hs_total = 0;
    int strb_total = 0;
    int beats_pushed = 0;
    int start_q[$];
    int end_q[$];
    int tid_q[$];
    int rise0 = -1;
    bit pv0 = 1'b0;
    bit in_pkt = 1'b0;
    bit cur_tid = 1'b0;
    int rdy_mode = 1;
    logic [CW-1:0] cm0 = '0;
    logic [CW-1:0] cm1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Queue one packet; optional run of tvalid-low bubbles before beat gap_at.
    task automatic push_pkt(input int p, input int n,
                            input logic [DW-1:0] base,
                            input int gap_at, input int gap_len);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    b.bub = 1'b1;
                    b.last = 1'b0;
                    b.data = '0;
                    if (p == 1) sq1.push_back(b);
                    else sq0.push_back(b);
                end
            end
            b.bub = 1'b0;
            b.last = (i == n - 1);
            b.data = base + DW'(i);
            e.last = b.last;
            e.data = b.data;
            if (p == 1) begin
                sq1.push_back(b);
                eq1.push_back(e);
            end else begin
                sq0.push_back(b);
                eq0.push_back(e);
            end
            beats_pushed++;
        end
        if (p == 1) cm1++;
        else cm0++;
    endtask

    task automatic clear_queues();
        sq0.delete();
        sq1.delete();
        eq0.delete();
        eq1.delete();
    endtask

    task automatic clear_logs();
        start_q.delete();
        end_q.delete();
        tid_q.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (k < budget &&
               !(sq0.size() == 0 && sq1.size() == 0 &&
                 eq0.size() == 0 && eq1.size() == 0 && !busy)) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s: timeout, %0d/%0d beats outstanding, required 0",
                     name, eq0.size(), eq1.size());
            clear_queues();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_queues();
        cm0 = '0;
        cm1 = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Drivers: present queue heads just after the edge, pop on handshake.
    initial begin
        bit h0;
        bit h1;
        bit p0;
        bit p1;
        p0 = 1'b0;
        p1 = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        force_v0 = 1'b0;
        axis_in0_tdata = '0;
        axis_in0_tlast = 1'b0;
        axis_in1_tdata = '0;
        axis_in1_tlast = 1'b0;
        axis_out_tready = 1'b0;
        forever begin
            @(negedge clk);
            h0 = axis_in0_tvalid & axis_in0_tready;
            h1 = axis_in1_tvalid & axis_in1_tready;
            @(posedge clk);
            #1;
            if (sq0.size() > 0 && (h0 || (p0 && sq0[0].bub)))
                void'(sq0.pop_front());
            if (sq1.size() > 0 && (h1 || (p1 && sq1[0].bub)))
                void'(sq1.pop_front());
            p0 = (sq0.size() > 0);
            p1 = (sq1.size() > 0);
            if (p0) begin
                v0 = !sq0[0].bub;
                axis_in0_tdata = sq0[0].data;
                axis_in0_tlast = sq0[0].last;
            end else begin
                v0 = 1'b0;
                axis_in0_tlast = 1'b0;
            end
            if (p1) begin
                v1 = !sq1[0].bub;
                axis_in1_tdata = sq1[0].data;
                axis_in1_tlast = sq1[0].last;
            end else begin
                v1 = 1'b0;
                axis_in1_tlast = 1'b0;
            end
            if (rdy_mode == 1) axis_out_tready = 1'b1;
            else axis_out_tready = ($urandom_range(3) != 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        bit   t;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_pkt = 1'b0;
                pv0 = 1'b0;
            end else begin
                if (axis_in0_tvalid && !pv0) rise0 = cyc;
                pv0 = axis_in0_tvalid;
                if (axis_out_tvalid && axis_out_tready) begin
                    hs_total++;
                    t = axis_out_tid;
                    if (in_pkt) check("no_interleave", t, cur_tid);
                    else start_q.push_back(cyc);
                    if ((t ? eq1.size() : eq0.size()) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_beat: tid %0d data %0h, required none",
                                 t, axis_out_tdata);
                    end else begin
                        e = t ? eq1.pop_front() : eq0.pop_front();
                        check("beat_data", axis_out_tdata, e.data);
                        check("beat_last", axis_out_tlast, e.last);
                    end
                    check("strb_on_hs", packet_strb, axis_out_tlast);
                    if (axis_out_tlast) begin
                        in_pkt = 1'b0;
                        end_q.push_back(cyc);
                        tid_q.push_back(int'(t));
                    end else begin
                        in_pkt = 1'b1;
                        cur_tid = t;
                    end
                end else begin
                    check("strb_idle", packet_strb, 1'b0);
                end
                if (packet_strb) strb_total++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb;
        int hb;
        int gaps;
        int p;
        int n;
        int ga;
        int exp_tid[4] = '{0, 1, 0, 1};
        logic [DW-1:0] base;

        // Reset values
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in0_tready", axis_in0_tready, 1'b0);
        check("rst_in1_tready", axis_in1_tready, 1'b0);
        check("rst_out_tvalid", axis_out_tvalid, 1'b0);
        check("rst_out_tlast", axis_out_tlast, 1'b0);
        check("rst_active_port", active_port, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_strb", packet_strb, 1'b0);
        check("rst_cnt0", pkt_count0, 4'd0);
        check("rst_cnt1", pkt_count1, 4'd0);

        // Single 3-beat packet on in0
        clear_logs();
        sb = strb_total;
        push_pkt(0, 3, 64'hA0, -1, 0);
        wait_drain("t1_drain", 100);
        check("t1_npkt", start_q.size(), 1);
        if (start_q.size() == 1 && end_q.size() == 1) begin
            check("t1_latency", start_q[0], rise0 + 1);
            check("t1_contig", end_q[0], start_q[0] + 2);
            check("t1_tid", tid_q[0], 0);
        end
        check("t1_cnt0", pkt_count0, 4'd1);
        check("t1_strb", strb_total - sb, 1);

        // Both ports busy with 2-beat packets: strict alternation
        do_reset();
        clear_logs();
        push_pkt(0, 2, 64'h100, -1, 0);
        push_pkt(1, 2, 64'h200, -1, 0);
        push_pkt(0, 2, 64'h110, -1, 0);
        push_pkt(1, 2, 64'h210, -1, 0);
        wait_drain("t2_drain", 200);
        check("t2_npkt", tid_q.size(), 4);
        if (tid_q.size() == 4 && start_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_order", tid_q[i], exp_tid[i]);
                check("t2_len", end_q[i], start_q[i] + 1);
            end
            for (int i = 0; i < 3; i++)
                check("t2_gap", start_q[i + 1], end_q[i] + 2);
        end
        check("t2_cnt0", pkt_count0, 4'd2);
        check("t2_cnt1", pkt_count1, 4'd2);

        // Lock: in1 packet with a 2-cycle stall while in0 toggles
        clear_logs();
        gaps = 0;
        @(negedge clk);
        push_pkt(1, 4, 64'h300, 2, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin
                check("lock_in0_tready", axis_in0_tready, 1'b0);
                if (!axis_out_tvalid) gaps++;
            end
            force_v0 = (busy && i >= 1 && i <= 4) ? i[0] : 1'b0;
        end
        force_v0 = 1'b0;
        wait_drain("lock_drain", 100);
        check("lock_gaps", gaps, 2);
        check("lock_npkt", tid_q.size(), 1);
        if (tid_q.size() == 1) check("lock_tid", tid_q[0], 1);
        check("lock_cnt1", pkt_count1, 4'd3);

        // Random backpressure, 100 mixed packets
        sb = strb_total;
        hb = hs_total;
        beats_pushed = 0;
        @(negedge clk);
        rdy_mode = 0;
        for (int k = 0; k < 100; k++) begin
            p = int'($urandom_range(1));
            n = int'($urandom_range(4, 1));
            ga = -1;
            if (n > 1 && $urandom_range(3) == 0)
                ga = int'($urandom_range(n - 1, 1));
            base = {$urandom, $urandom};
            push_pkt(p, n, base, ga, int'($urandom_range(2, 1)));
        end
        wait_drain("bp_drain", 5000);
        rdy_mode = 1;
        check("bp_beats", hs_total - hb, beats_pushed);
        check("bp_strb", strb_total - sb, 100);
        check("bp_cnt0", pkt_count0, cm0);
        check("bp_cnt1", pkt_count1, cm1);

        // Counter wrap with CW=4
        do_reset();
        sb = strb_total;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            push_pkt(0, 2, 64'h500 + DW'(i * 4), -1, 0);
            wait_drain("wrap_drain", 100);
            check("wrap_cnt0", pkt_count0, 64'(i % 16));
        end
        check("wrap_strb", strb_total - sb, 17);

        // Reset in the middle of a 5-beat packet
        hb = hs_total;
        @(negedge clk);
        push_pkt(0, 5, 64'h600, -1, 0);
        begin
            int k = 0;
            while (k < 50 && hs_total < hb + 2) begin
                @(posedge clk);
                k++;
            end
            check("mid_reach_beat2", hs_total - hb, 2);
        end
        #2;
        resetn = 1'b0;
        #1;
        check("mid_out_tvalid", axis_out_tvalid, 1'b0);
        check("mid_out_tlast", axis_out_tlast, 1'b0);
        check("mid_in0_tready", axis_in0_tready, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_strb", packet_strb, 1'b0);
        check("mid_cnt0", pkt_count0, 4'd0);
        clear_queues();
        cm0 = '0;
        cm1 = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        clear_logs();
        push_pkt(1, 2, 64'h700, -1, 0);
        wait_drain("mid_drain", 100);
        check("mid_npkt", tid_q.size(), 1);
        if (tid_q.size() == 1) check("mid_tid", tid_q[0], 1);
        check("mid_active", active_port, 1'b1);
        check("mid_cnt1", pkt_count1, 4'd1);
        check("mid_cnt0_after", pkt_count0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
